// File: rtl/rvc_pkg.sv
// Shared constants and types for the RV32I -> RVC compression packer.
// Immediates here are unsigned: the matching decompressor zero-extends them.
package rvc_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_SRA  = 7'b0100000;

    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q1 = 2'b01;
    localparam logic [1:0] Q2 = 2'b10;

    localparam logic [15:0] C_NOP = 16'h0001;

    typedef struct packed {
        logic        is_comp;
        logic [15:0] comp16;
    } comp_res_t;

    // x8..x15 are the only registers reachable through 3-bit RVC fields
    function automatic logic is_creg(input logic [4:0] r);
        return r[4:3] == 2'b01;
    endfunction

endpackage

// File: rtl/rvc_compressor.sv
// Combinational RV32I -> RVC encoder for the supported subset.
// Emits is_comp only when the decompressor would rebuild the exact instruction.
module rvc_compressor
    import rvc_pkg::*;
(
    input  logic [31:0] instr,
    output comp_res_t   res
);

    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  lw_u, sw_u;
    logic [11:0] j_imm;
    logic [8:0]  b_imm;

    always_comb begin
        opc   = instr[6:0];
        rd    = instr[11:7];
        f3    = instr[14:12];
        rs1   = instr[19:15];
        rs2   = instr[24:20];
        f7    = instr[31:25];
        lw_u  = {instr[26:22], 2'b00};
        sw_u  = {instr[26:25], instr[11:9], 2'b00};
        j_imm = {instr[20], instr[30:21], 1'b0};
        b_imm = {instr[28:25], instr[11:8], 1'b0};
    end

    always_comb begin
        res = '0;
        case (opc)
            OPC_LOAD: if (f3 == F3_LW && is_creg(rs1) && is_creg(rd) &&
                          instr[31:27] == 5'd0 && instr[21:20] == 2'd0) begin
                res.is_comp = 1'b1;
                res.comp16  = {3'b010, lw_u[5:3], rs1[2:0], lw_u[2], lw_u[6], rd[2:0], Q0};
            end
            OPC_STORE: if (f3 == F3_LW && is_creg(rs1) && is_creg(rs2) &&
                           instr[31:27] == 5'd0 && instr[8:7] == 2'd0) begin
                res.is_comp = 1'b1;
                res.comp16  = {3'b110, sw_u[5:3], rs1[2:0], sw_u[2], sw_u[6], rs2[2:0], Q0};
            end
            OPC_OP_IMM: begin
                case (f3)
                    // addi x0,x0,0 falls out of this encoding as C_NOP
                    F3_ADD: if (rd == rs1 && instr[31:26] == 6'd0) begin
                        res.is_comp = 1'b1;
                        res.comp16  = {3'b000, instr[25], rd, instr[24:20], Q1};
                    end
                    F3_AND: if (rd == rs1 && is_creg(rd) && instr[31:26] == 6'd0) begin
                        res.is_comp = 1'b1;
                        res.comp16  = {3'b100, instr[25], 2'b10, rd[2:0], instr[24:20], Q1};
                    end
                    F3_SR: if (rd == rs1 && is_creg(rd) && (f7 == F7_ZERO || f7 == F7_SRA)) begin
                        res.is_comp = 1'b1;
                        res.comp16  = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], instr[24:20], Q1};
                    end
                    F3_SLL: if (rd == rs1 && rd != 5'd0 && f7 == F7_ZERO) begin
                        res.is_comp = 1'b1;
                        res.comp16  = {3'b000, 1'b0, rd, instr[24:20], Q2};
                    end
                    default: ;
                endcase
            end
            OPC_JAL: if (rd[4:1] == 4'd0 && !instr[31] && instr[19:12] == 8'd0) begin
                res.is_comp = 1'b1;
                res.comp16  = {(rd[0] ? 3'b001 : 3'b101), j_imm[11], j_imm[4], j_imm[9:8],
                               j_imm[10], j_imm[6], j_imm[7], j_imm[3:1], j_imm[5], Q1};
            end
            OPC_BRANCH: if ((f3 == F3_BEQ || f3 == F3_BNE) && rs2 == 5'd0 && is_creg(rs1) &&
                            !instr[31] && !instr[7] && instr[30:29] == 2'd0) begin
                res.is_comp = 1'b1;
                res.comp16  = {(f3[0] ? 3'b111 : 3'b110), b_imm[8], b_imm[4:3], rs1[2:0],
                               b_imm[7:6], b_imm[2:1], b_imm[5], Q1};
            end
            OPC_JALR: if (f3 == F3_JALR && instr[31:20] == 12'd0 && rd[4:1] == 4'd0 &&
                          rs1 != 5'd0) begin
                res.is_comp = 1'b1;
                res.comp16  = {3'b100, rd[0], rs1, 5'd0, Q2};
            end
            OPC_OP: if (f7 == F7_ZERO && f3 == F3_ADD && rd != 5'd0 && rs2 != 5'd0) begin
                if (rs1 == 5'd0) begin
                    res.is_comp = 1'b1;
                    res.comp16  = {3'b100, 1'b0, rd, rs2, Q2};
                end else if (rs1 == rd) begin
                    res.is_comp = 1'b1;
                    res.comp16  = {3'b100, 1'b1, rd, rs2, Q2};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rvc_compress_packer.sv
// Compresses RV32I instructions where possible and packs the 16/32-bit
// results into little-endian 32-bit words ([15:0] is the earlier halfword).
module rvc_compress_packer
    import rvc_pkg::*;
#(
    parameter bit ENABLE_COMPRESS = 1'b1,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_word,
    output logic             idle,
    output logic [CNT_W-1:0] comp_cnt
);

    comp_res_t   cres;
    logic        acc, use_c, flush_go;
    logic        p_vld, pv_n, ov_n;
    logic [15:0] p_half, ph_n;
    logic [31:0] ow_n;
    logic [CNT_W-1:0] cnt_n;

    rvc_compressor u_comp (
        .instr (in_instr),
        .res   (cres)
    );

    assign in_ready = ~out_valid | out_ready;
    assign idle     = ~p_vld & ~out_valid;

    always_comb begin
        acc      = in_valid & in_ready;
        use_c    = ENABLE_COMPRESS & cres.is_comp;
        // an input handshake always wins over a flush request
        flush_go = ~acc & flush & p_vld & in_ready;
        ov_n     = out_valid & ~out_ready;
        ow_n     = out_word;
        pv_n     = p_vld;
        ph_n     = p_half;
        cnt_n    = comp_cnt;
        if (acc) begin
            if (use_c) begin
                if (&comp_cnt == 1'b0)
                    cnt_n = comp_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                if (p_vld) begin
                    ov_n = 1'b1;
                    ow_n = {cres.comp16, p_half};
                    pv_n = 1'b0;
                end else begin
                    pv_n = 1'b1;
                    ph_n = cres.comp16;
                end
            end else if (p_vld) begin
                // full-width instruction straddles two words
                ov_n = 1'b1;
                ow_n = {in_instr[15:0], p_half};
                ph_n = in_instr[31:16];
            end else begin
                ov_n = 1'b1;
                ow_n = in_instr;
            end
        end else if (flush_go) begin
            ov_n = 1'b1;
            ow_n = {C_NOP, p_half};
            pv_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= '0;
            p_vld     <= 1'b0;
            p_half    <= '0;
            comp_cnt  <= '0;
        end else begin
            out_valid <= ov_n;
            out_word  <= ow_n;
            p_vld     <= pv_n;
            p_half    <= ph_n;
            comp_cnt  <= cnt_n;
        end
    end

endmodule

// File: doc/rvc_compress_packer.md
Name: rvc_compress_packer

Overview:
- Write-side counterpart of the RVC decompression path.
- Accepts a stream of 32-bit RV32I instructions and replaces each one with its 16-bit RVC form when the existing decompression logic reproduces it bit-exactly.
- Packs the resulting 16/32-bit instructions into little-endian 32-bit words for the program-image / instruction-memory writer.
- Supported RVC subset: C.ADD, C.MV, C.ADDI, C.NOP, C.ANDI, C.SLLI, C.SRLI, C.SRAI, C.LW, C.SW, C.BEQZ, C.BNEZ, C.J, C.JAL, C.JR, C.JALR.

Parameters:
- ENABLE_COMPRESS, 1, 0 = never compress (pure pass-through packer).
- CNT_W, 16, width of the saturating compressed-instruction counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_instr valid.
- in_ready  output  1  block can accept in_instr.
- in_instr  input  32  uncompressed instruction.
- flush  input  1  level request: emit pending halfword padded with C.NOP.
- out_valid  output  1  out_word valid.
- out_ready  input  1  downstream accepts out_word.
- out_word  output  32  packed word; [15:0] is the earlier halfword.
- idle  output  1  no pending halfword and no held output.
- comp_cnt  output  CNT_W  count of instructions emitted compressed (saturating).

Behaviour:
- Reset values: out_valid=0, out_word=0, pending-valid=0, pending-half=0, comp_cnt=0. in_ready=1 and idle=1 after reset. Reset mid-stream drops pending and held data.
- in_ready = ~out_valid | out_ready (combinational). Handshake occurs when in_valid & in_ready. out_word must stay stable while out_valid & ~out_ready.
- Compressibility rules (all must hold; otherwise the instruction is passed through full width):
  - LW/SW: funct3=010; rd/rs2 and rs1 in x8..x15; offset in 0..124, multiple of 4.
  - ADDI: rd==rs1; imm 0..63. The instruction addi x0,x0,0 maps to C.NOP (0x0001).
  - ANDI: rd==rs1 in x8..x15; imm 0..63.
  - SRLI/SRAI: rd==rs1 in x8..x15; shamt 0..31.
  - SLLI: rd==rs1 != x0; shamt 0..31.
  - JAL: rd is x0 (C.J) or x1 (C.JAL); offset 0..4094.
  - BEQ/BNE: rs2=x0; rs1 in x8..x15; offset 0..510.
  - JALR: imm=0; rd is x0 or x1; rs1 != x0.
  - ADD: rd != x0 and rs2 != x0. If rs1==x0 emit C.MV; if rs1==rd emit C.ADD.
  - Negative immediates are never compressed, because the decompression path zero-extends.
- Accept actions (one output word maximum per cycle). C = 16-bit compressed form, W = full 32-bit instruction, P = pending halfword:
  - C, no P: P<=C; no output.
  - C, P: out_word<={C,P}; P cleared.
  - W, no P: out_word<=W.
  - W, P: out_word<={W[15:0],P}; P<=W[31:16].
- Latency: 1 cycle from handshake to out_valid when a word completes.
- Flush:
  - Acts only in a cycle with no input handshake, P valid, and output slot free (~out_valid | out_ready).
  - Action: out_word<={16'h0001,P}; P cleared.
  - Flush with no P is a no-op.
  - in_valid has priority over flush.
- idle = ~P-valid & ~out_valid.
- comp_cnt increments once per accepted instruction that is compressed, and saturates at all-ones.
- Non-32-bit input (in_instr[1:0]!=2'b11) is passed through unmodified as W.
- With ENABLE_COMPRESS=0, every instruction is treated as W.

Decomposition:
- Package rvc_pkg holds:
  - opcode constants: LOAD, STORE, OP_IMM, OP, JAL, JALR, BRANCH;
  - funct3/funct7 constants;
  - C_NOP = 16'h0001;
  - the quadrant codes.
- Sub-module rvc_compressor (combinational): in_instr -> {is_comp, comp16}.
- The top level holds the handshake, pending register, output register and counter.

Test Plan:
- Two accepts of addi x8,x8,5 (0x00540413) -> no output after the first; then out_word=0x04150415; comp_cnt=2.
- lw x9,4(x10) (0x00452483), then flush=1 -> out_word=0x00014144; idle=1 afterwards.
- 0x0415, then lui x1,0x12345 (0x123450b7), then 0x00540413 -> out_word 0x50b70415, then 0x04151234.
- addi x8,x8,-1 (0xfff40413), then beq x8,x0,-4 (0xfe040ee3) -> both passed through unchanged; comp_cnt=0.
- Hold out_ready=0 with out_valid=1 for 5 cycles -> in_ready=0; out_word stable; no input consumed.
- Assert rst_n=0 with P valid and out_valid=1 -> out_valid=0 and idle=1 immediately; no stale half in later words.
